// File: rtl/demod_segment_serializer.sv
// Captures ten upstream segments and streams them one word per beat.
// Optional XOR checksum beat: define SEG_CHECKSUM_EN.
module demod_segment_serializer #(
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_go,
  output logic              up_start,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] seg_0,
  input  logic [DATA_W-1:0] seg_1,
  input  logic [DATA_W-1:0] seg_2,
  input  logic [DATA_W-1:0] seg_3,
  input  logic [DATA_W-1:0] seg_4,
  input  logic [DATA_W-1:0] seg_5,
  input  logic [DATA_W-1:0] seg_6,
  input  logic [DATA_W-1:0] seg_7,
  input  logic [DATA_W-1:0] seg_8,
  input  logic [DATA_W-1:0] seg_9,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_index,
  output logic              out_last,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

`ifdef SEG_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd10;
`else
  localparam logic [3:0] LAST_IDX = 4'd9;
`endif
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic              up_start_q, up_start_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              tmo_q, tmo_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [3:0]        out_index_q, out_index_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] cap_q [10];
  logic [DATA_W-1:0] cap_d [10];
  logic [DATA_W-1:0] seg_in [10];
  logic [DATA_W-1:0] words [16];
  logic [3:0]        nxt_idx;
`ifdef SEG_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q, chk_d, seg_xor;
`endif

  assign seg_in[0] = seg_0;
  assign seg_in[1] = seg_1;
  assign seg_in[2] = seg_2;
  assign seg_in[3] = seg_3;
  assign seg_in[4] = seg_4;
  assign seg_in[5] = seg_5;
  assign seg_in[6] = seg_6;
  assign seg_in[7] = seg_7;
  assign seg_in[8] = seg_8;
  assign seg_in[9] = seg_9;
  assign nxt_idx   = out_index_q + 4'd1;

  // Beat-indexed view of the captured frame.
  always_comb begin
    for (int i = 0; i < 16; i++) words[i] = '0;
    for (int i = 0; i < 10; i++) words[i] = cap_q[i];
`ifdef SEG_CHECKSUM_EN
    words[10] = chk_q;
    seg_xor = '0;
    for (int i = 0; i < 10; i++) seg_xor = seg_xor ^ seg_in[i];
`endif
  end

  // Next-state and output-register logic for IDLE/REQ/SEND.
  always_comb begin
    state_d     = state_q;
    up_start_d  = up_start_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    tmo_d       = tmo_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    wait_cnt_d  = wait_cnt_q;
    cap_d       = cap_q;
`ifdef SEG_CHECKSUM_EN
    chk_d       = chk_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (frame_go) begin
          up_start_d = 1'b1;
          busy_d     = 1'b1;
          tmo_d      = 1'b0;
          wait_cnt_d = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (up_valid) begin
          cap_d       = seg_in;
`ifdef SEG_CHECKSUM_EN
          chk_d       = seg_xor;
`endif
          up_start_d  = 1'b0;
          out_data_d  = seg_in[0];
          out_index_d = '0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          state_d     = SEND;
        end else if (wait_cnt_q == WAIT_LAST) begin
          tmo_d      = 1'b1;
          up_start_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          if (out_index_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            state_d     = IDLE;
          end else begin
            out_index_d = nxt_idx;
            out_data_d  = words[nxt_idx];
            out_last_d  = (nxt_idx == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      up_start_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      wait_cnt_q  <= '0;
      for (int i = 0; i < 10; i++) cap_q[i] <= '0;
`ifdef SEG_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      up_start_q  <= up_start_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      wait_cnt_q  <= wait_cnt_d;
      cap_q       <= cap_d;
`ifdef SEG_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign up_start    = up_start_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;
  assign out_data    = out_data_q;
  assign out_index   = out_index_q;

endmodule

// File: tb/tb_demod_segment_serializer.sv
// Directed bench for demod_segment_serializer with an upstream model.
// Frame length follows SEG_CHECKSUM_EN.
module tb_demod_segment_serializer;

`ifdef SEG_CHECKSUM_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset, frame_go, out_ready;
  logic        up_start, up_valid;
  logic [31:0] seg [10];
  logic [31:0] ref_seg [10];
  logic [31:0] out_data;
  logic        out_valid, out_last, busy, timeout_err;
  logic [3:0]  out_index;
  logic [3:0]  up_cnt = 4'd0;
  logic        up_en = 1'b1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Upstream model: counts while start is high, valid from count 3.
  always @(posedge clk) begin
    if (!up_start) up_cnt <= 4'd0;
    else if (up_cnt != 4'd15) up_cnt <= up_cnt + 4'd1;
  end
  assign up_valid = up_en && (up_cnt >= 4'd3);

  demod_segment_serializer #(.DATA_W(32), .WAIT_MAX(8)) dut (
    .clk(clk), .reset(reset), .frame_go(frame_go),
    .up_start(up_start), .up_valid(up_valid),
    .seg_0(seg[0]), .seg_1(seg[1]), .seg_2(seg[2]),
    .seg_3(seg[3]), .seg_4(seg[4]), .seg_5(seg[5]),
    .seg_6(seg[6]), .seg_7(seg[7]), .seg_8(seg[8]),
    .seg_9(seg[9]),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index),
    .out_last(out_last), .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] x;
    x = '0;
    if (k < 10) return ref_seg[k];
    for (int i = 0; i < 10; i++) x = x ^ ref_seg[i];
    return x;
  endfunction

  task automatic set_seg(input logic [31:0] base,
                         input logic [31:0] inc);
    for (int i = 0; i < 10; i++) begin
      seg[i]     = base + inc * 32'(i);
      ref_seg[i] = base + inc * 32'(i);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((busy || out_valid) && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (busy || out_valid) begin
      errors++;
      $display("FAIL %s drain: busy=%b still set after %0d cycles",
               tag, busy, n);
    end
  endtask

  task automatic run_frame(input string tag);
    frame_go = 1'b1;
    step();
    frame_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({up_start, out_valid} !== 2'b10) begin
        errors++;
        $display("FAIL %s req%0d: start/valid=%b want 10",
                 tag, i, {up_start, out_valid});
      end
      step();
    end
    checks++;
    if ({up_start, out_valid} !== 2'b01) begin
      errors++;
      $display("FAIL %s first: start/valid=%b want 01",
               tag, {up_start, out_valid});
    end
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (out_index !== 4'(k) || out_data !== exp_word(k) ||
          out_last !== (k == NB - 1) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s beat%0d: idx=%0d data=%h last=%b want %0d %h %b",
                 tag, k, out_index, out_data, out_last,
                 k, exp_word(k), (k == NB - 1));
      end
      step();
    end
    checks++;
    if ({out_valid, busy, out_last, up_start} !== 4'b0) begin
      errors++;
      $display("FAIL %s end: valid/busy/last/start=%b want 0000",
               tag, {out_valid, busy, out_last, up_start});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    frame_go = 1'b0;
    out_ready = 1'b0;
    set_seg(32'h0, 32'h0);
    step();
    step();
    checks++;
    if ({up_start, out_valid, out_last, busy, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset ctl: got %b want 00000",
               {up_start, out_valid, out_last, busy, timeout_err});
    end
    checks++;
    if ({out_index, out_data} !== 36'h0) begin
      errors++;
      $display("FAIL reset data: idx=%0d data=%h want 0 0",
               out_index, out_data);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_seg(32'h1000_0000, 32'h1);
    out_ready = 1'b1;
    run_frame("basic");
  endtask

  task automatic test_backpressure();
    int got;
    int cyc;
    set_seg(32'h3000_0000, 32'h11);
    got = 0;
    cyc = 0;
    frame_go = 1'b1;
    step();
    frame_go = 1'b0;
    while (got < NB && cyc < 80) begin
      out_ready = cyc[0];
      if (out_valid) begin
        checks++;
        if (out_index !== 4'(got) || out_data !== exp_word(got) ||
            out_last !== (got == NB - 1)) begin
          errors++;
          $display("FAIL bp word%0d: idx=%0d data=%h last=%b want %0d %h",
                   got, out_index, out_data, out_last, got, exp_word(got));
        end
        if (out_ready) got++;
      end
      step();
      cyc++;
    end
    checks++;
    if (got != NB || out_valid || busy) begin
      errors++;
      $display("FAIL bp count: got %0d words valid=%b want %0d 0",
               got, out_valid, NB);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_timeout();
    up_en = 1'b0;
    out_ready = 1'b1;
    frame_go = 1'b1;
    step();
    frame_go = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      checks++;
      if ({up_start, timeout_err, busy} !== 3'b101) begin
        errors++;
        $display("FAIL tmo wait%0d: start/err/busy=%b want 101",
                 i, {up_start, timeout_err, busy});
      end
    end
    step();
    checks++;
    if ({up_start, timeout_err, busy} !== 3'b010) begin
      errors++;
      $display("FAIL tmo fire: start/err/busy=%b want 010",
               {up_start, timeout_err, busy});
    end
    up_en = 1'b1;
    frame_go = 1'b1;
    step();
    frame_go = 1'b0;
    checks++;
    if ({timeout_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL tmo clear: err/busy=%b want 01",
               {timeout_err, busy});
    end
    drain("tmo");
  endtask

  task automatic test_reset_mid_send();
    int n;
    set_seg(32'h4000_0000, 32'h3);
    out_ready = 1'b1;
    n = 0;
    frame_go = 1'b1;
    step();
    frame_go = 1'b0;
    while (!(out_valid && out_index == 4'd4) && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (!(out_valid && out_index == 4'd4)) begin
      errors++;
      $display("FAIL rst wait: idx=%0d valid=%b want 4 1",
               out_index, out_valid);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({up_start, out_valid, out_last, busy, timeout_err,
         out_index, out_data} !== 41'h0) begin
      errors++;
      $display("FAIL rst mid: idx=%0d data=%h valid=%b busy=%b want 0",
               out_index, out_data, out_valid, busy);
    end
    reset = 1'b1;
    step();
    run_frame("after_rst");
  endtask

  task automatic test_ignored();
    set_seg(32'h5000_0000, 32'h1);
    out_ready = 1'b1;
    frame_go = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 10; i++) seg[i] = 32'hDEAD_0000 + 32'(i);
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (out_index !== 4'(k) || out_data !== exp_word(k) ||
          out_valid !== 1'b1) begin
        errors++;
        $display("FAIL ign beat%0d: idx=%0d data=%h want %0d %h",
                 k, out_index, out_data, k, exp_word(k));
      end
      step();
    end
    checks++;
    if ({busy, up_start, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL ign idle: busy/start/valid=%b want 000",
               {busy, up_start, out_valid});
    end
    step();
    checks++;
    if ({busy, up_start} !== 2'b11) begin
      errors++;
      $display("FAIL ign restart: busy/start=%b want 11",
               {busy, up_start});
    end
    frame_go = 1'b0;
    drain("ign");
  endtask

`ifdef SEG_CHECKSUM_EN
  task automatic test_checksum();
    set_seg(32'h1, 32'h1);
    out_ready = 1'b1;
    run_frame("chk");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_reset_mid_send();
    test_ignored();
`ifdef SEG_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/demod_segment_serializer.md
Name: demod_segment_serializer

Overview:
- Downstream consumer of the 3-cycle demodulation segment stage, which produces ten 32-bit segments plus start/valid/busy control.
- Drives that stage's start input, waits for its valid, and captures all ten segments in one cycle.
- Releases start, then streams the segments out one word per beat over a valid/ready interface to the next pipe stage.
- Guards against a stalled upstream with a timeout flag.

Parameters:
- DATA_W, 32, segment and output word width.
- WAIT_MAX, 8, max cycles spent in REQ waiting for up_valid before timeout. Legal range is 4..255, since the upstream latency is 3.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
- frame_go  input  1  request one frame; sampled only in IDLE.
- up_start  output  1  start to the upstream segment stage.
- up_valid  input  1  valid from the upstream segment stage.
- seg_0 .. seg_9  input  DATA_W each  upstream segment outputs.
- out_data  output  DATA_W  current output word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word this cycle.
- out_index  output  4  index of the current word (0..9, or 10 for the checksum).
- out_last  output  1  final beat of the frame.
- busy  output  1  frame in progress (REQ or SEND).
- timeout_err  output  1  sticky error, cleared by the next accepted frame_go or by reset.

Behaviour:
- Reset: on any posedge with reset==0:
  - state goes to IDLE;
  - up_start, out_valid, out_last, busy and timeout_err go to 0;
  - out_data, out_index, capture registers and wait_cnt go to 0.
  - Applies mid-frame: up_start drops at that edge and partial frames are discarded.
- Upstream stage behaviour that this block relies on:
  - Its counter increments on each edge while start==1, and valid goes high when the count reaches 3.
  - Its counter clears on the first edge where start==0.
- IDLE:
  - If frame_go==1: up_start<=1, busy<=1, timeout_err<=0, wait_cnt<=0, go to REQ.
  - up_valid and out_ready are ignored.
- REQ (up_start held at 1):
  - If up_valid==1:
    - capture seg_0..seg_9, and the checksum if enabled;
    - up_start<=0;
    - out_data<=seg_0, out_index<=0, out_valid<=1;
    - go to SEND.
  - Else if wait_cnt==WAIT_MAX-1: timeout_err<=1, up_start<=0, busy<=0, go to IDLE.
  - Else wait_cnt<=wait_cnt+1.
  - frame_go is ignored.
- SEND:
  - Word k is transferred on an edge where out_valid&&out_ready.
  - While stalled (out_ready==0), out_data, out_index and out_last hold.
  - After a transfer, if the beat was not the last: out_index++, out_data<=next captured word, out_last<=1 if the next beat is the last.
  - On transfer of the last beat: out_valid<=0, out_last<=0, busy<=0, go to IDLE.
  - up_valid is ignored in SEND (upstream has already cleared its counter).
- Latency, with the companion upstream stage:
  - frame_go sampled at edge N gives up_start=1 after N.
  - up_valid goes high after N+3.
  - out_valid goes high after N+4, so there are 4 cycles from frame_go to the first word.
  - With out_ready held at 1, beat 0 is on the output after N+4 and transfers at N+5; the last beat transfers at N+14 (N+15 with checksum).
  - Next frame_go is accepted at the edge after the return to IDLE, giving a minimum frame period of 15 cycles (16 with checksum).
- Edge cases:
  - Captured words are frozen once captured; later changes on seg_* have no effect on the frame.
  - up_valid arriving on the same edge as wait_cnt reaching WAIT_MAX-1 counts as success; valid has priority over timeout.

Optional Feature:
- Macro: SEG_CHECKSUM_EN.
- Defined:
  - A checksum word, the XOR of seg_0..seg_9, is registered at capture.
  - It is sent as beat 10 with out_index=10 and out_last=1.
  - Frames are 11 beats.
- Not defined:
  - Frames are 10 beats, with out_last on out_index=9.
  - No checksum register is present.

Test Plan:
- Basic frame: seg_k=32'h1000_0000+k, out_ready=1, pulse frame_go.
  - up_start is high for 4 cycles.
  - out_valid rises 4 cycles after frame_go is sampled.
  - Words 0x10000000..0x10000009 appear on out_index 0..9, with out_last only on index 9; busy is 0 afterwards.
- Backpressure: out_ready low on every other cycle.
  - out_data/out_index hold while stalled.
  - All 10 words arrive in order, none duplicated or dropped.
- Timeout: up_valid tied to 0, WAIT_MAX=8.
  - up_start drops and timeout_err=1 exactly 8 cycles after entering REQ; busy is 0.
  - The next frame_go clears timeout_err.
- Reset mid-SEND: drive reset=0 for one cycle after out_index=4.
  - All outputs are 0 at that edge, state is IDLE.
  - A new frame_go then produces a full, correct frame from index 0.
- Ignored inputs: frame_go held high through the whole frame, and seg_* changed after capture.
  - Only one frame of captured values is emitted.
  - A second frame starts on the edge after the return to IDLE.
- SEG_CHECKSUM_EN: seg_k=k+1.
  - Beat 10 carries 32'h0000_000B (XOR of 1..10) with out_last=1.
  - Beat 9 has out_last=0.
